adc_receiver: RTL

ADC_RECEIVER -- requirements
Module: adc_receiver

---
 rtl/synth_pkg.sv | 16 +
 rtl/sync_edge.sv | 40 ++++
 rtl/adc_receiver.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// Shared types and constants for the audio codec receive path.
package synth_pkg;

  localparam int unsigned AUDIO_W = 16;

  typedef enum logic [2:0] {
    StIdle,
    StSkipL,
    StShiftL,
    StWaitR,
    StSkipR,
    StShiftR,
    StWaitL
  } adc_rx_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous input with one-cycle rise/fall strobes
// derived from the synchronized level.
module sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = d_i;
    for (int i = 1; i < int'(STAGES); i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/adc_receiver.sv
// I2S ADC receiver: oversamples the codec clocks on Clk, deserializes left/right samples
// and hands complete pairs to a consumer through a valid/ready hold register.
module adc_receiver
  import synth_pkg::*;
#(
  parameter int unsigned DATA_W      = AUDIO_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              AUD_BCLK,
  input  logic              AUD_ADCLRCK,
  input  logic              AUD_ADCDAT,
  input  logic              enable,
  input  logic              sample_ready,
  input  logic              overrun_clr,
  output logic [DATA_W-1:0] LDATA_IN,
  output logic [DATA_W-1:0] RDATA_IN,
  output logic              sample_valid,
  output logic              overrun,
  output logic              frame_err
);

  localparam int unsigned     CntW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);

  logic bclk_rise, bclk_fall_unused, bclk_level_unused;
  logic lrck_rise, lrck_fall, lrck_level_unused;

  sync_edge #(
    .STAGES(SYNC_STAGES)
  ) u_bclk_sync (
    .clk_i (Clk),
    .rst_i (Reset),
    .d_i   (AUD_BCLK),
    .q_o   (bclk_level_unused),
    .rise_o(bclk_rise),
    .fall_o(bclk_fall_unused)
  );

  sync_edge #(
    .STAGES(SYNC_STAGES)
  ) u_lrck_sync (
    .clk_i (Clk),
    .rst_i (Reset),
    .d_i   (AUD_ADCLRCK),
    .q_o   (lrck_level_unused),
    .rise_o(lrck_rise),
    .fall_o(lrck_fall)
  );

  // Same depth as the BCLK chain so the bit seen on a rise strobe is the one present at the edge.
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic                   bit_in;

  always_comb begin
    dat_sync_d    = dat_sync_q;
    dat_sync_d[0] = AUD_ADCDAT;
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      dat_sync_d[i] = dat_sync_q[i-1];
    end
  end

  assign bit_in = dat_sync_q[SYNC_STAGES-1];

  adc_rx_state_t     state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] lsh_q, lsh_d, rsh_q, rsh_d, r_next;
  logic [DATA_W-1:0] ldata_q, ldata_d, rdata_q, rdata_d;
  logic              valid_q, valid_d, overrun_q, overrun_d, ferr_q, ferr_d;
  logic              publish, lrck_edge;

  assign lrck_edge = lrck_fall | lrck_rise;
  assign r_next    = {rsh_q[DATA_W-2:0], bit_in};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lsh_d   = lsh_q;
    rsh_d   = rsh_q;
    ferr_d  = 1'b0;
    publish = 1'b0;
    if (!enable) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (lrck_fall) state_d = StSkipL;
        end
        StSkipL, StSkipR: begin
          if (lrck_edge) begin
            ferr_d  = 1'b1;
            state_d = lrck_fall ? StSkipL : StIdle;
          end else if (bclk_rise) begin
            state_d = (state_q == StSkipL) ? StShiftL : StShiftR;
            cnt_d   = '0;
          end
        end
        StShiftL: begin
          if (lrck_edge) begin
            ferr_d  = 1'b1;
            state_d = lrck_fall ? StSkipL : StIdle;
          end else if (bclk_rise) begin
            lsh_d = {lsh_q[DATA_W-2:0], bit_in};
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == LastBit) state_d = StWaitR;
          end
        end
        StWaitR: begin
          if (lrck_rise) state_d = StSkipR;
        end
        StShiftR: begin
          if (lrck_edge) begin
            ferr_d  = 1'b1;
            state_d = lrck_fall ? StSkipL : StIdle;
          end else if (bclk_rise) begin
            rsh_d = r_next;
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == LastBit) begin
              state_d = StWaitL;
              publish = 1'b1;
            end
          end
        end
        StWaitL: begin
          if (lrck_fall) state_d = StSkipL;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // An unconsumed pair is never overwritten; a new pair is dropped and flagged instead.
  always_comb begin
    ldata_d   = ldata_q;
    rdata_d   = rdata_q;
    valid_d   = valid_q & ~sample_ready;
    overrun_d = overrun_q & ~overrun_clr;
    if (publish) begin
      if (valid_q && !sample_ready) begin
        overrun_d = 1'b1;
      end else begin
        ldata_d = lsh_q;
        rdata_d = r_next;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      dat_sync_q <= '0;
      state_q    <= StIdle;
      cnt_q      <= '0;
      lsh_q      <= '0;
      rsh_q      <= '0;
      ldata_q    <= '0;
      rdata_q    <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      dat_sync_q <= dat_sync_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lsh_q      <= lsh_d;
      rsh_q      <= rsh_d;
      ldata_q    <= ldata_d;
      rdata_q    <= rdata_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      ferr_q     <= ferr_d;
    end
  end

  assign LDATA_IN     = ldata_q;
  assign RDATA_IN     = rdata_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;
  assign frame_err    = ferr_q;

endmodule
